// File: rtl/result_display_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : result_display_7seg
//  Description : Converts a 16-bit unsigned result to decimal with a
//                sequential double-dabble converter (one shift per clock) and
//                scans it onto a 4-digit multiplexed common-anode 7-segment
//                display with leading-zero blanking and overflow dashes.
//  Revision    : 1.0  initial release
// ============================================================================
module result_display_7seg #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int                c_cnt_w   = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [6:0]        c_seg_blank = 7'b1111111;
    localparam logic [6:0]        c_seg_dash  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_start;
    logic                w_shift;
    logic                w_commit;
    logic                w_busy;
    logic [15:0]         w_start_val;

    logic [15:0]         r_bin;
    logic [19:0]         r_bcd;
    logic [18:0]         w_bcd_adj;
    logic [3:0]          r_iter;
    logic [15:0]         r_src;
    logic [15:0]         r_pend_val;
    logic                r_pend;

    logic [15:0]         r_disp;
    logic                r_ovf;

    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_nxt;
    logic [3:0]          w_dig;
    logic                w_blank;
    logic [6:0]          w_seg_nxt;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Converter next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (load) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                w_shift = 1'b1;
                if (r_iter == 4'd15) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_commit = 1'b1;
                // A strobe in this very cycle is newer than any pending value
                if (load || r_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy        = w_busy;
    assign w_start_val = load ? value : r_pend_val;

    // Add-3 correction; the fifth nibble never reaches 5 before a shift for a
    // 16-bit input, so only the four low nibbles need correcting.
    always_comb begin
        w_bcd_adj = {r_bcd[18:16], 16'd0};
        for (int k = 0; k < 4; k++) begin
            w_bcd_adj[k*4 +: 4] = (r_bcd[k*4 +: 4] >= 4'd5) ? (r_bcd[k*4 +: 4] + 4'd3)
                                                             : r_bcd[k*4 +: 4];
        end
    end

    // Double-dabble datapath and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_src  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_disp <= r_bcd[15:0];
                r_ovf  <= (r_bcd[19:16] != 4'd0) || (r_src > 16'd9999);
            end
            if (w_start) begin
                r_bin  <= w_start_val;
                r_src  <= w_start_val;
                r_bcd  <= '0;
                r_iter <= '0;
            end else if (w_shift) begin
                r_bcd  <= {w_bcd_adj, r_bin[15]};
                r_bin  <= {r_bin[14:0], 1'b0};
                r_iter <= r_iter + 4'd1;
            end
        end
    end

    // Pending request captured while a conversion is running; last one wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else if (r_state == ST_DONE) begin
            r_pend <= 1'b0;
        end else if (load && (r_state == ST_CONV)) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
        end
    end

    // Refresh counter and digit index
    assign w_idx_nxt = (r_cnt == c_cnt_max) ? (r_idx + 2'd1) : r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= (r_cnt == c_cnt_max) ? '0 : (r_cnt + c_cnt_w'(1));
            r_idx <= w_idx_nxt;
        end
    end

    // Segment pattern for the digit that will be active after this edge
    always_comb begin
        w_dig   = r_disp[w_idx_nxt*4 +: 4];
        w_blank = 1'b0;
        case (w_idx_nxt)
            2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
            2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
            2'd3:    w_blank = (r_disp[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
        if (r_ovf)        w_seg_nxt = c_seg_dash;
        else if (w_blank) w_seg_nxt = c_seg_blank;
        else              w_seg_nxt = f_seg(w_dig);
    end

    // Anode and segment outputs registered together to avoid ghosting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= c_seg_blank;
        end else begin
            r_an  <= ~(4'b0001 << w_idx_nxt);
            r_seg <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign ovf = r_ovf;
    assign dp  = 1'b1;

endmodule
`default_nettype wire
